// File: rtl/sensor_i2c_pkg.sv
// Shared types and helpers for the sensor I2C write master: FSM state and
// SCL quarter encodings, plus the channel byte selector used to fill the frame buffer.
package sensor_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

  localparam logic ADDR_RW_WRITE = 1'b0;

  // Widest channel vector the selector accepts (32 channels of 4 bytes).
  localparam int unsigned MAX_DATA_W = 1024;

  // Byte idx (in transmit order) of channel ch; endian=1 sends the MS byte first.
  function automatic logic [7:0] ch_byte_sel(input logic [MAX_DATA_W-1:0] data,
                                             input int unsigned ch,
                                             input int unsigned idx,
                                             input logic endian,
                                             input int unsigned ch_bytes);
    int unsigned byte_pos;
    byte_pos = endian ? (ch_bytes - 1 - idx) : idx;
    return 8'(data >> ((ch * ch_bytes + byte_pos) * 8));
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period strobe for SCL generation: one-cycle tick every CLK_DIV clocks,
// restartable so every frame starts on the same phase.
module i2c_tick_gen #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = !clr && (cnt == CNT_W'(CLK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sensor_i2c_tx.sv
// I2C write master: snapshots NUM_CH channels and sends address + channel bytes
// with per-byte ACK checking, aborting with STOP on NACK.
module sensor_i2c_tx
  import sensor_i2c_pkg::*;
#(
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned CH_BYTES = 2,
  parameter int unsigned CLK_DIV  = 50
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [6:0]                     i2c_address,
  input  logic                           endian,
  input  logic [NUM_CH*CH_BYTES*8-1:0]   ch_data,
  input  logic                           sda_i,
  output logic                           scl_oe,
  output logic                           sda_oe,
  output logic                           data_enable,
  output logic                           reg_freeze,
  output logic                           bsy,
  output logic                           nack,
  output logic                           done
);

  localparam int unsigned N      = 1 + NUM_CH * CH_BYTES;
  localparam int unsigned BYTE_W = $clog2(N + 1);

  state_t            state, state_next;
  quarter_t          qtr;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic              tick;
  logic              qtr_last;
  logic              last_byte;
  logic              sda_meta, sda_sync;
  logic [N*8-1:0]    load_vec;
  logic [N*8-1:0]    shift_buf;
  logic [7:0]        cur_byte;
  logic              tx_bit;
  logic [MAX_DATA_W-1:0] ch_data_ext;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state inside {IDLE, LOAD, DONE}),
    .tick  (tick)
  );

  assign qtr_last  = tick && (qtr == Q3);
  assign last_byte = (byte_cnt == BYTE_W'(N - 1));

  // Frame image, first byte to send in the top byte lane.
  assign ch_data_ext          = MAX_DATA_W'(ch_data);
  assign load_vec[N*8-1 -: 8] = {i2c_address, ADDR_RW_WRITE};
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    for (genvar i = 0; i < CH_BYTES; i++) begin : g_byte
      assign load_vec[(N - 2 - (k * CH_BYTES + i)) * 8 +: 8] =
        ch_byte_sel(ch_data_ext, k, i, endian, CH_BYTES);
    end
  end

  assign cur_byte = shift_buf[N*8-1 -: 8];
  assign tx_bit   = cur_byte[~bit_cnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
    end
  end

  // NOTE: the frame buffer is pure datapath, always loaded before it is read,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      shift_buf <= load_vec;
    end else if (state == ACK && qtr_last && !sda_sync) begin
      shift_buf <= shift_buf << 8;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (qtr_last) state_next = BIT;
      BIT:     if (qtr_last && bit_cnt == 3'd7) state_next = ACK;
      ACK:     if (qtr_last) state_next = (sda_sync || last_byte) ? STOP : BIT;
      STOP:    if (qtr_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qtr      <= Q0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      nack     <= 1'b0;
    end else begin
      if (state inside {IDLE, LOAD, DONE}) begin
        qtr <= Q0;
      end else if (tick) begin
        qtr <= quarter_t'(qtr + 2'd1);
      end

      if (state == LOAD) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (state == BIT && qtr_last) begin
        bit_cnt <= bit_cnt + 3'd1;
      end else if (state == ACK && qtr_last) begin
        byte_cnt <= byte_cnt + BYTE_W'(1);
      end

      if (state == IDLE && start) begin
        nack <= 1'b0;
      end else if (state == ACK && qtr_last && sda_sync) begin
        nack <= 1'b1;
      end
    end
  end

  always_comb begin
    scl_oe      = 1'b0;
    sda_oe      = 1'b0;
    data_enable = 1'b0;
    reg_freeze  = 1'b0;
    bsy         = 1'b0;
    done        = 1'b0;
    case (state)
      LOAD: begin
        data_enable = 1'b1;
        reg_freeze  = 1'b1;
      end
      START: begin
        bsy        = 1'b1;
        reg_freeze = 1'b1;
        sda_oe     = (qtr != Q0);
        scl_oe     = (qtr == Q3);
      end
      BIT: begin
        bsy        = 1'b1;
        reg_freeze = 1'b1;
        scl_oe     = (qtr inside {Q0, Q1});
        sda_oe     = !tx_bit;
      end
      ACK: begin
        bsy        = 1'b1;
        reg_freeze = 1'b1;
        scl_oe     = (qtr inside {Q0, Q1});
      end
      STOP: begin
        bsy        = 1'b1;
        reg_freeze = 1'b1;
        scl_oe     = (qtr == Q0);
        sda_oe     = (qtr != Q3);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sensor_i2c_tx.sv
// Bench for sensor_i2c_tx: a sampled-bus I2C slave model decodes the frame,
// chooses ACK/NACK per byte and flags illegal SDA activity while SCL is high.
module tb_sensor_i2c_tx;

  localparam int NUM_CH   = 3;
  localparam int CH_BYTES = 2;
  localparam int CLK_DIV  = 4;
  localparam int N        = 1 + NUM_CH * CH_BYTES;
  localparam int DW       = NUM_CH * CH_BYTES * 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [6:0]    i2c_address;
  logic          endian;
  logic [DW-1:0] ch_data;
  logic          sda_i;
  logic          scl_oe, sda_oe, data_enable, reg_freeze, bsy, nack, done;

  logic slave_pull = 1'b0;
  logic scl_line, sda_line;
  assign scl_line = ~scl_oe;
  assign sda_line = ~(sda_oe | slave_pull);
  assign sda_i    = sda_line;

  always #5 clk = ~clk;

  sensor_i2c_tx #(.NUM_CH(NUM_CH), .CH_BYTES(CH_BYTES), .CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .i2c_address (i2c_address),
    .endian      (endian),
    .ch_data     (ch_data),
    .sda_i       (sda_i),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe),
    .data_enable (data_enable),
    .reg_freeze  (reg_freeze),
    .bsy         (bsy),
    .nack        (nack),
    .done        (done)
  );

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected byte b of a frame, straight from the byte-order rules.
  function automatic logic [7:0] model_byte(input logic [6:0] a, input logic [DW-1:0] d,
                                            input logic e, input int b);
    int ch, pos, sig;
    if (b == 0) return {a, 1'b0};
    ch  = (b - 1) / CH_BYTES;
    pos = (b - 1) % CH_BYTES;
    sig = e ? (CH_BYTES - 1 - pos) : pos;
    return 8'(d >> (8 * (ch * CH_BYTES + sig)));
  endfunction

  // Slave / protocol monitor state
  bit         mon_en = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, cur_scl, cur_sda;
  bit         in_frame = 1'b0;
  int         bit_idx = 0, byte_no = 0, illegal = 0, starts = 0, stops = 0, de_cnt = 0;
  int         nack_byte = -1;
  logic [7:0] shreg = 8'h00;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_scl   = 1'b1;
      prev_sda   = 1'b1;
      in_frame   = 1'b0;
      bit_idx    = 0;
      slave_pull = 1'b0;
    end else begin
      cur_scl = scl_line;
      cur_sda = sda_line;
      if (data_enable) de_cnt++;
      if (prev_scl && cur_scl && cur_sda != prev_sda) begin
        if (!cur_sda) begin
          if (in_frame) illegal++;
          in_frame = 1'b1;
          bit_idx  = 0;
          byte_no  = 0;
          starts++;
        end else begin
          // the STOP's own SCL rise looks like the first bit of a new byte
          if (!in_frame || bit_idx != 1) illegal++;
          in_frame   = 1'b0;
          slave_pull = 1'b0;
          stops++;
        end
      end else if (!prev_scl && cur_scl && cur_sda != prev_sda) begin
        illegal++;
      end
      if (!prev_scl && cur_scl && in_frame) begin
        if (bit_idx < 8) shreg = {shreg[6:0], cur_sda};
        bit_idx++;
      end
      if (prev_scl && !cur_scl && in_frame) begin
        if (bit_idx == 8) begin
          rx_q.push_back(shreg);
          slave_pull = (byte_no != nack_byte);
        end else if (bit_idx == 9) begin
          slave_pull = 1'b0;
          bit_idx    = 0;
          byte_no++;
        end
      end
      prev_scl = cur_scl;
      prev_sda = cur_sda;
    end
  end

  task automatic run_frame(input logic [6:0] a, input logic [DW-1:0] d, input logic e,
                           input int nack_at, input bit disturb, input string tag);
    int sent, exp_done, n;
    sent     = (nack_at < 0) ? N : nack_at + 1;
    exp_done = 2 + 4 * CLK_DIV * (2 + 9 * sent);
    @(negedge clk);
    i2c_address = a;
    ch_data     = d;
    endian      = e;
    nack_byte   = nack_at;
    rx_q.delete();
    de_cnt  = 0;
    illegal = 0;
    starts  = 0;
    stops   = 0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 1;
    while (!done && n < exp_done + 50) begin
      @(negedge clk);
      n++;
      if (n == 2) check({tag, "/nack_cleared"}, 64'(nack), 64'(0));
      if (n == 100) check({tag, "/busy_mid"}, 64'({bsy, reg_freeze}), 64'(2'b11));
      if (disturb && n == 300) begin
        start   = 1'b1;
        ch_data = DW'({$urandom, $urandom});
      end
      if (disturb && n == 301) start = 1'b0;
    end
    check({tag, "/done_cycle"}, 64'(n), 64'(exp_done));
    check({tag, "/done_flags"}, 64'({done, bsy, reg_freeze}), 64'(3'b100));
    check({tag, "/nack"}, 64'(nack), 64'(nack_at >= 0));
    check({tag, "/byte_count"}, 64'(rx_q.size()), 64'(sent));
    for (int b = 0; b < sent && b < rx_q.size(); b++)
      check($sformatf("%s/byte%0d", tag, b), 64'(rx_q[b]), 64'(model_byte(a, d, e, b)));
    check({tag, "/data_enable_pulses"}, 64'(de_cnt), 64'(1));
    check({tag, "/bus_protocol"}, {16'(illegal), 16'(starts), 16'(stops)},
          {16'd0, 16'd1, 16'd1});
    @(negedge clk);
    check({tag, "/done_one_cycle"}, 64'(done), 64'(0));
    repeat (20) @(negedge clk);
    check({tag, "/idle_after"}, 64'({bsy, reg_freeze, data_enable, nack}),
          64'({3'b000, nack_at >= 0}));
  endtask

  logic [DW-1:0] d0, rd;
  logic [6:0]    ra;
  logic          re;
  int            rn, w;

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    i2c_address = '0;
    endian      = 1'b0;
    ch_data     = '0;
    repeat (3) @(negedge clk);
    check("reset/outputs", 64'({scl_oe, sda_oe, data_enable, reg_freeze, bsy, nack, done}), 64'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle/outputs", 64'({scl_oe, sda_oe, data_enable, reg_freeze, bsy, nack, done}), 64'(0));

    d0 = {16'h1234, 16'hBEEF, 16'hA55A};
    run_frame(7'h29, d0, 1'b1, -1, 1'b0, "msb_first");
    run_frame(7'h29, d0, 1'b0, -1, 1'b0, "lsb_first");
    run_frame(7'h29, d0, 1'b1, 0, 1'b0, "nack_addr");
    run_frame(7'h29, d0, 1'b0, N - 1, 1'b0, "nack_last");
    run_frame(7'h29, d0, 1'b1, -1, 1'b1, "mid_frame_disturb");

    for (int r = 0; r < 4; r++) begin
      ra = 7'($urandom);
      rd = DW'({$urandom, $urandom});
      re = 1'($urandom);
      rn = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, N - 1));
      run_frame(ra, rd, re, rn, 1'b0, $sformatf("rand%0d", r));
    end

    // Reset in the middle of a data byte, then a fresh frame.
    @(negedge clk);
    i2c_address = 7'h11;
    ch_data     = d0;
    endian      = 1'b1;
    nack_byte   = -1;
    rx_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w     = 0;
    while (!(byte_no == 1 && bit_idx == 3 && scl_line == 1'b0) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("rst_mid/reached_bit", 64'(w < 2000), 64'(1));
    #1 rst_n = 1'b0;
    mon_en = 1'b0;
    #1 check("rst_mid/bus_released", 64'({scl_oe, sda_oe, bsy, reg_freeze, done}), 64'(0));
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(7'h3C, ~d0, 1'b0, -1, 1'b0, "after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sensor_i2c_tx.md
# sensor_i2c_tx

Parametrised I2C write master that serialises a frozen snapshot of NUM_CH sensor channels, each CH_BYTES wide, to an external I2C slave. It sits between the channel data registers (clear/red/green/blue/IR and future channels) and the open-drain I2C pads. It generates SCL from the system clock, performs per-byte ACK checking, and aborts with STOP on NACK. It replaces the fixed five-channel, 16-bit transmitter with one clock domain, configurable geometry and a proper completion handshake.

## Interface
Parameters:
- NUM_CH, 5, number of channels transmitted per frame (≥1)
- CH_BYTES, 2, bytes per channel (1..4)
- CLK_DIV, 50, clk cycles per SCL quarter-period (≥2); SCL period = 4·CLK_DIV

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request one frame; sampled only in IDLE
- i2c_address  in  7  slave address; sent as {i2c_address, 1'b0} (write)
- endian  in  1  1 = MS byte of each channel first, 0 = LS byte first; captured at start
- ch_data  in  NUM_CH·CH_BYTES·8  channel k occupies bits [k·CH_BYTES·8 +: CH_BYTES·8]
- sda_i  in  1  SDA pad input (asynchronous)
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- data_enable  out  1  one-cycle pulse: snapshot taken, upstream LFSR/data source may advance
- reg_freeze  out  1  high while a frame is in flight
- bsy  out  1  high from the START condition through the end of STOP
- nack  out  1  sticky: last frame aborted on NACK; cleared at next accepted start
- done  out  1  one-cycle pulse after STOP completes (success or abort)

## Operation
- Reset: all outputs 0 (scl_oe = sda_oe = 0, i.e. bus released); state IDLE; counters cleared. A reset during a frame releases the bus immediately, without a STOP.
- States: IDLE → LOAD → START → BIT → ACK → (BIT | STOP) → DONE → IDLE.
- IDLE: start=1 → LOAD. Otherwise stay.
- LOAD (1 cycle): capture i2c_address, endian and ch_data into a shift buffer. Pulse data_enable. Set reg_freeze. Clear nack.
- START (4 quarters): Q0 SDA and SCL released. Q1–Q2 SDA low, SCL released. Q3 SCL low. bsy rises on entry to START.
- Byte order: address byte first, then channel 0 … NUM_CH−1. Within a channel the byte order follows the captured endian. Bits are sent MSB first. Total bytes N = 1 + NUM_CH·CH_BYTES.
- BIT (8 bits, 4 quarters each): Q0–Q1 SCL low, with SDA updated on the first cycle of Q0. Q2–Q3 SCL released.
- ACK (4 quarters): SDA released. Sample sda_i through a 2-flop synchroniser on the last cycle of Q3.
  - 0 → next byte, or STOP after byte N.
  - 1 → set nack, go to STOP.
- STOP (4 quarters): Q0 SCL low, SDA low. Q1–Q2 SCL released, SDA low. Q3 both released.
- DONE (1 cycle): done=1, bsy=0, reg_freeze=0 → IDLE.
- start asserted outside IDLE is ignored and not queued.

## Timing
- start high at cycle 0 → LOAD at cycle 1, with data_enable=1 on cycle 1 only. START begins at cycle 2.
- Quarter tick every CLK_DIV cycles. The divider restarts at entry to START, so phases are aligned frame to frame.
- Successful frame: 1 + 4·CLK_DIV·(2 + 9·N) + 1 cycles from start to the done pulse.
  - Defaults: N = 11, so 20 202 cycles.
- NACK on byte j (0-based): done arrives 4·CLK_DIV·(9·(N−1−j)) cycles earlier than a successful frame. No further bytes are sent after the failing ACK.
- The ch_data change during a frame has no effect. The snapshot is held until DONE.

## Structure
- Package sensor_i2c_pkg holds:
  - state enum: IDLE, LOAD, START, BIT, ACK, STOP, DONE
  - quarter enum: Q0–Q3
  - localparam ADDR_RW_WRITE = 1'b0
  - function ch_byte_sel(data, ch, idx, endian)
- Sub-module i2c_tick_gen (parameter CLK_DIV; ports clk, rst_n, clr, tick) produces the quarter tick.
- The top level holds the FSM, the quarter/bit/byte counters (byte counter width $clog2(N+1)), the snapshot buffer and the sda_i synchroniser.

## Test plan
- CLK_DIV=4, NUM_CH=1, CH_BYTES=2, addr=7'h29, ch_data=16'hA55A, endian=1, slave ACKs all:
  - bytes 0x52, 0xA5, 0x5A observed on the bus
  - done at cycle 1+16·29+1 = 466; nack=0
- Same stimulus with endian=0 → bytes 0x52, 0x5A, 0xA5.
- Defaults, slave NACKs the address byte:
  - nack=1
  - STOP follows directly after the address ACK slot; no data bits
  - done 4·50·90 = 18 000 cycles earlier than a successful frame
- start pulsed again mid-frame and ch_data changed mid-frame:
  - transmitted bytes are unchanged
  - data_enable pulses exactly once per frame
- rst_n asserted during BIT:
  - scl_oe = sda_oe = bsy = reg_freeze = 0 immediately
  - after release, start yields a fresh, complete frame
- Protocol checker, all frames: SDA never changes while SCL is released, except for the START and STOP edges.
